// File: rtl/rdback_packer_pkg.sv
// rdback_packer_pkg -- shared constants and helpers for the readback packer.
//   BEATS    : DRAM read-data beats packed into one readback word (fixed 4)
//   beat_off : bit offset of beat k inside a packed word (beat 0 in the LSBs)
package rdback_packer_pkg;

   localparam int BEATS = 4;

   function automatic int beat_off(input logic [1:0] k, input int dq);
      return int'(k) * dq;
   endfunction

endpackage

// File: rtl/rdback_packer_if.sv
// rdback_packer_if -- bus bundle between the readback packer and its
// surroundings.
//   rd_valid / rd_data  : DRAM read-data beat stream (no backpressure)
//   flush               : discard partial word and all queued words
//   rdback_fifo_empty / rdback_fifo_rden / rdback_data : FWFT word port
//   fifo_count          : number of queued words
//   overflow / partial  : sticky drop flag, partial-word-held flag
// modport master drives the beat stream and pops; modport slave is the packer.
// DEPTH must match the DEPTH of the packer it is connected to.
interface rdback_packer_if
   import rdback_packer_pkg::*;
#(
   parameter int DQ_WIDTH = 64,
   parameter int DEPTH    = 16
);

   logic                         rd_valid;
   logic [DQ_WIDTH-1:0]          rd_data;
   logic                         flush;
   logic                         rdback_fifo_empty;
   logic                         rdback_fifo_rden;
   logic [DQ_WIDTH*BEATS-1:0]    rdback_data;
   logic [$clog2(DEPTH):0]       fifo_count;
   logic                         overflow;
   logic                         partial;

   modport master (
      output rd_valid, rd_data, flush, rdback_fifo_rden,
      input  rdback_fifo_empty, rdback_data, fifo_count, overflow, partial
   );

   modport slave (
      input  rd_valid, rd_data, flush, rdback_fifo_rden,
      output rdback_fifo_empty, rdback_data, fifo_count, overflow, partial
   );

endinterface

// File: rtl/rdback_fifo.sv
// rdback_fifo -- first-word-fall-through FIFO for packed readback words.
//   clk, rst_n : clock, synchronous active-low reset (control state only)
//   clr        : synchronous clear of pointers and count (wins over wr/rd)
//   wr_en/wr_data : push; accepted when not full, or when full with a pop
//   rd_en      : pop; ignored while empty
//   rd_data    : head entry, valid whenever empty is low
//   empty/full/count : occupancy, derived from count
module rdback_fifo #(
   parameter int W     = 256,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [W-1:0]              wr_data,
   input  logic                      rd_en,
   output logic [W-1:0]              rd_data,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = rd_en && !empty;
   // When full, a coincident pop frees the head slot in the same edge, so the
   // write to wr_ptr (== rd_ptr) lands after the head has been consumed.
   assign do_push = wr_en && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; entries are only observed after being written.
   always_ff @(posedge clk) begin
      if (rst_n && !clr && do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/rdback_packer.sv
// rdback_packer -- packs 4 consecutive DRAM read-data beats into one wide
// readback word and queues it in an FWFT FIFO.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : rdback_packer_if.slave (beat stream in, word FIFO out, flags)
// The 4th beat completes word_q; the word is pushed on the following edge
// and becomes visible one edge later (2 cycles from 4th beat to data).
module rdback_packer
   import rdback_packer_pkg::*;
#(
   parameter int DQ_WIDTH = 64,
   parameter int BEATS    = 4,
   parameter int DEPTH    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   rdback_packer_if.slave     bus
);

   localparam int WORD_W = DQ_WIDTH * BEATS;

   logic [1:0]        beat_cnt;
   logic [WORD_W-1:0] word_q, word_nxt;
   logic              push_vld;
   logic              overflow_q;
   logic              fifo_full, fifo_empty, pop;

   assign pop = bus.rdback_fifo_rden && !fifo_empty;

   always_comb begin
      word_nxt = word_q;
      word_nxt[beat_off(beat_cnt, DQ_WIDTH) +: DQ_WIDTH] = bus.rd_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt   <= '0;
         push_vld   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         // A pending push dropped by flush is cancelled, not an overflow.
         if (push_vld && !bus.flush && fifo_full && !pop) overflow_q <= 1'b1;
         if (bus.flush) begin
            beat_cnt <= '0;
            push_vld <= 1'b0;
         end else begin
            push_vld <= bus.rd_valid && (beat_cnt == 2'd3);
            if (bus.rd_valid) beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   // word_q holds the complete word during the push cycle: the next word's
   // beat 0 only overwrites slot 0 at the same edge the push is taken.
   always_ff @(posedge clk) begin
      if (rst_n && !bus.flush && bus.rd_valid) word_q <= word_nxt;
   end

   rdback_fifo #(
      .W     (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (bus.flush),
      .wr_en   (push_vld),
      .wr_data (word_q),
      .rd_en   (bus.rdback_fifo_rden),
      .rd_data (bus.rdback_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (bus.fifo_count)
   );

   assign bus.rdback_fifo_empty = fifo_empty;
   assign bus.overflow          = overflow_q;
   assign bus.partial           = (beat_cnt != 2'd0);

endmodule

// File: doc/rdback_packer.md
RDBACK_PACKER -- requirements
Module: rdback_packer

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 64, meaning width of one DRAM read-data beat.
REQ-002 SHALL have parameter BEATS, default 4, meaning beats packed per readback word; fixed at 4.
REQ-003 SHALL have parameter DEPTH, default 16, meaning readback FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port rd_valid, input, 1, read-data beat present this cycle.
REQ-007 SHALL have port rd_data, input, DQ_WIDTH, read-data beat.
REQ-008 SHALL have port flush, input, 1, discard the partial word and all FIFO contents.
REQ-009 SHALL have port rdback_fifo_empty, output, 1, no packed word available.
REQ-010 SHALL have port rdback_fifo_rden, input, 1, pop the head word.
REQ-011 SHALL have port rdback_data, output, DQ_WIDTH*4, head word (first-word fall-through).
REQ-012 SHALL have port fifo_count, output, log2(DEPTH)+1, number of stored words.
REQ-013 SHALL have port overflow, output, 1, sticky flag: a word was dropped.
REQ-014 SHALL have port partial, output, 1, high when 1 to 3 beats of a word are held.

Function
REQ-015 SHALL count accepted beats with a 2-bit beat_cnt that increments on every rd_valid and wraps 3 -> 0.
REQ-016 SHALL place beat k in bits [k*DQ_WIDTH +: DQ_WIDTH] of the word, so beat 0 is in the LSBs.
REQ-017 SHALL push the assembled word into the FIFO in the cycle after the 4th beat (beat_cnt == 3 with rd_valid) is accepted.
REQ-018 SHALL present the pushed word with rdback_fifo_empty low one cycle after the push, giving 2 cycles from 4th beat to visible data.
REQ-019 SHALL drive rdback_data with the head entry whenever rdback_fifo_empty is low; the value is don't-care when empty.
REQ-020 SHALL pop on rdback_fifo_rden && !rdback_fifo_empty, and SHALL ignore rden while empty.
REQ-021 SHALL, when a push and a pop coincide, perform both and leave fifo_count unchanged, including when the FIFO is full.
REQ-022 SHALL, when the FIFO is full with no coincident pop, drop the pushed word, set overflow, and keep beat_cnt advancing normally.
REQ-023 SHALL accept rd_valid every cycle with no backpressure, because DRAM read data cannot be stalled.
REQ-024 SHALL wrap the FIFO read and write pointers modulo DEPTH and derive full/empty from fifo_count.
REQ-025 SHALL, on flush, clear beat_cnt, pointers, count and any pending push in the next cycle, and SHALL ignore any rd_valid in the flush cycle.
REQ-026 SHALL keep overflow set until reset; flush does not clear it.
REQ-027 SHALL drive partial as (beat_cnt != 0).

Reset
REQ-028 SHALL, on rst_n low at a clk edge, set beat_cnt=0, pointers=0, fifo_count=0, rdback_fifo_empty=1, overflow=0, partial=0 and cancel any pending push.
REQ-029 SHALL, if reset lands mid-word, discard that word; the next beat after reset is beat 0.
REQ-030 SHALL NOT require FIFO storage to be reset; contents are don't-care until written.

Structure
REQ-031 SHALL place the BEATS constant and the beat-index-to-bit-offset function in the shared package.
REQ-032 SHALL implement storage as one sub-module, rdback_fifo (FWFT, parameterised by width and depth); packing logic stays in rdback_packer.

Verification
REQ-033 SHALL verify a burst: beats 0x0..0x3 on consecutive cycles -> rdback_data={0x3,0x2,0x1,0x0}, empty falls 2 cycles after the 4th beat, count=1.
REQ-034 SHALL verify gapped beats: 4 beats with idle cycles between them -> one identical word, with partial=1 between beats 1 and 4.
REQ-035 SHALL verify overflow: fill 16 words, no pops, 4 more beats -> count=16, overflow=1, the head word is still the first word.
REQ-036 SHALL verify push and pop together when full: pop and 4th-beat push in the same cycle -> count stays 16, overflow stays 0, and word order is kept.
REQ-037 SHALL verify flush mid-word: 2 beats, flush, then 4 beats -> exactly one word containing only the post-flush beats.
REQ-038 SHALL verify reset mid-word: 3 beats, rst_n low 1 cycle, then 4 beats -> one word of the post-reset beats, and empty=1 during reset.
